// File: rtl/bsg_link_pkg.sv
// Shared definitions for the SDR link upstream transmitter and downstream receiver.
// Holds the link FSM state type and the default width / credit constants.
package bsg_link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } link_state_e;

    localparam int unsigned LINK_WIDTH_DEFAULT          = 32;
    localparam int unsigned LINK_CHANNEL_WIDTH_DEFAULT  = 8;
    localparam int unsigned LINK_LG_FIFO_DEPTH_DEFAULT  = 3;
    localparam int unsigned LINK_LG_CREDIT_DEC_DEFAULT  = 1;

endpackage

// File: rtl/bsg_link_sdr_upstream_if.sv
// Core-side handshake, io byte lane and credit-return signals of the SDR upstream link.
// The slave modport is the transmitter's view; master is the core/link-partner view.
interface bsg_link_sdr_upstream_if
    import bsg_link_pkg::*;
#(
    parameter int unsigned width_p         = LINK_WIDTH_DEFAULT,
    parameter int unsigned channel_width_p = LINK_CHANNEL_WIDTH_DEFAULT
);

    logic [width_p-1:0]         core_data_i;
    logic                       core_v_i;
    logic                       core_ready_o;
    logic [channel_width_p-1:0] io_data_o;
    logic                       io_valid_o;
    logic                       token_i;

    modport master (
        output core_data_i,
        output core_v_i,
        output token_i,
        input  core_ready_o,
        input  io_data_o,
        input  io_valid_o
    );

    modport slave (
        input  core_data_i,
        input  core_v_i,
        input  token_i,
        output core_ready_o,
        output io_data_o,
        output io_valid_o
    );

endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready FIFO; ready_o reflects only the pre-edge fill level,
// so an enqueue into a full FIFO is refused even when a dequeue happens on that edge.
module bsg_two_fifo
    import bsg_link_pkg::*;
#(
    parameter int unsigned width_p = LINK_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               ready_i
);

    logic [width_p-1:0] mem_q [2];
    logic [width_p-1:0] mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               enq, deq;

    assign ready_o = rst_n && (count_q != 2'd2);
    assign v_o     = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign enq     = v_i && ready_o;
    assign deq     = v_o && ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bsg_link_sdr_upstream.sv
// SDR link transmitter: buffers core words, serializes them LSB byte first on the io lane,
// and launches a word only while downstream credit is available.
module bsg_link_sdr_upstream
    import bsg_link_pkg::*;
#(
    parameter int unsigned width_p                = LINK_WIDTH_DEFAULT,
    parameter int unsigned channel_width_p        = LINK_CHANNEL_WIDTH_DEFAULT,
    parameter int unsigned lg_fifo_depth_p        = LINK_LG_FIFO_DEPTH_DEFAULT,
    parameter int unsigned lg_credit_decimation_p = LINK_LG_CREDIT_DEC_DEFAULT
) (
    input logic                    clk,
    input logic                    rst_n,
    bsg_link_sdr_upstream_if.slave link
);

    localparam int unsigned BEATS    = width_p / channel_width_p;
    localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CREDIT_W = lg_fifo_depth_p + 1;
    localparam int unsigned SUM_W    = CREDIT_W + 1;

    localparam logic [BEAT_W-1:0]   BEAT_LAST   = BEAT_W'(BEATS - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(1 << lg_fifo_depth_p);
    localparam logic [SUM_W-1:0]    CREDIT_MAX  = SUM_W'(1 << lg_fifo_depth_p);
    localparam logic [SUM_W-1:0]    TOKEN_INC   = SUM_W'(1 << lg_credit_decimation_p);

    link_state_e                state_q, state_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [width_p-1:0]         shift_q, shift_d;
    logic [CREDIT_W-1:0]        credit_q, credit_d;
    logic [channel_width_p-1:0] io_data_q, io_data_d;
    logic                       io_valid_q, io_valid_d;

    logic [width_p-1:0]         fifo_data;
    logic                       fifo_v;
    logic                       fifo_ready;
    logic                       word_done;
    logic                       launch;
    logic [SUM_W-1:0]           credit_sum;

    bsg_two_fifo #(
        .width_p (width_p)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (link.core_data_i),
        .v_i     (link.core_v_i),
        .ready_o (fifo_ready),
        .data_o  (fifo_data),
        .v_o     (fifo_v),
        .ready_i (launch)
    );

    // The first byte goes straight to the io register on the launch edge, so the
    // shift register only ever holds the bytes still to be sent.
    assign word_done = (state_q == SEND) && (beat_q == BEAT_LAST);
    assign launch    = ((state_q == IDLE) || word_done) && fifo_v && (credit_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            shift_q    <= '0;
            credit_q   <= CREDIT_INIT;
            io_data_q  <= '0;
            io_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            shift_q    <= shift_d;
            credit_q   <= credit_d;
            io_data_q  <= io_data_d;
            io_valid_q <= io_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = SEND;
            SEND:    if (word_done && !launch) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_d     = beat_q;
        shift_d    = shift_q;
        io_data_d  = io_data_q;
        io_valid_d = io_valid_q;
        if (launch) begin
            io_data_d  = fifo_data[channel_width_p-1:0];
            shift_d    = fifo_data >> channel_width_p;
            beat_d     = '0;
            io_valid_d = 1'b1;
        end else if (word_done) begin
            beat_d     = '0;
            io_valid_d = 1'b0;
        end else if (state_q == SEND) begin
            io_data_d  = shift_q[channel_width_p-1:0];
            shift_d    = shift_q >> channel_width_p;
            beat_d     = beat_q + 1'b1;
        end

        credit_sum = {1'b0, credit_q}
                   + (link.token_i ? TOKEN_INC : '0)
                   - (launch ? SUM_W'(1) : '0);
        credit_d   = credit_sum[CREDIT_W-1:0];
    end

    assign link.core_ready_o = fifo_ready;
    assign link.io_data_o    = io_data_q;
    assign link.io_valid_o   = io_valid_q;

    // Returning more tokens than words sent is a partner protocol error, not clamped.
    credit_overflow_a: assert property (
        @(posedge clk) disable iff (!rst_n) credit_sum <= CREDIT_MAX
    );

endmodule

// File: tb/tb_bsg_link_sdr_upstream.sv
// Directed and randomized checks of the SDR upstream transmitter against
// hand-computed byte sequences and a byte-lane reassembly scoreboard.
module tb_bsg_link_sdr_upstream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsg_link_sdr_upstream_if #(.width_p(32), .channel_width_p(8)) lif ();

    bsg_link_sdr_upstream #(
        .width_p                (32),
        .channel_width_p        (8),
        .lg_fifo_depth_p        (3),
        .lg_credit_decimation_p (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (lif)
    );

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    logic [31:0] rx_q [$];
    logic [31:0] exp_q [$];
    int unsigned beat_cnt = 0;
    int unsigned run_cnt = 0;
    int unsigned byte_idx = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] acc = '0;

    // io-lane monitor: reassembles words and counts beats and valid runs
    always @(negedge clk) begin
        if (!rst_n) begin
            byte_idx   = 0;
            prev_valid = 1'b0;
        end else begin
            if (lif.io_valid_o) begin
                acc[byte_idx*8 +: 8] = lif.io_data_o;
                beat_cnt++;
                if (!prev_valid) run_cnt++;
                if (byte_idx == 3) begin
                    rx_q.push_back(acc);
                    byte_idx = 0;
                end else begin
                    byte_idx++;
                end
            end
            prev_valid = lif.io_valid_o;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        lif.core_v_i = 1'b0;
        lif.token_i = 1'b0;
        lif.core_data_i = '0;
        repeat (3) step();
        rx_q.delete();
        exp_q.delete();
        beat_cnt = 0;
        run_cnt = 0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        int unsigned n = 0;
        lif.core_v_i = 1'b1;
        lif.core_data_i = w;
        while (!lif.core_ready_o && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            check_eq("push_timeout", 32'(n), 32'd0);
        end else begin
            exp_q.push_back(w);
            step();
        end
        lif.core_v_i = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int unsigned i);
        return 32'hA0B0C0D0 ^ (32'(i) * 32'h01010101);
    endfunction

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        lif.core_v_i = 1'b0;
        lif.token_i = 1'b0;
        lif.core_data_i = '0;

        // reset values while rst_n held low
        repeat (2) step();
        check_eq("rst_ready", 32'(lif.core_ready_o), 32'd0);
        check_eq("rst_valid", 32'(lif.io_valid_o), 32'd0);
        check_eq("rst_data", 32'(lif.io_data_o), 32'd0);
        check_eq("rst_credit", 32'(dut.credit_q), 32'd8);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready", 32'(lif.core_ready_o), 32'd1);

        // single word: bytes AA,BB,CC,DD starting in the 2nd cycle after accept
        push(32'hDDCCBBAA);
        check_eq("t1_lat_valid", 32'(lif.io_valid_o), 32'd0);
        step();
        check_eq("t1_b0_valid", 32'(lif.io_valid_o), 32'd1);
        check_eq("t1_b0", 32'(lif.io_data_o), 32'hAA);
        check_eq("t1_credit", 32'(dut.credit_q), 32'd7);
        step();
        check_eq("t1_b1", 32'(lif.io_data_o), 32'hBB);
        step();
        check_eq("t1_b2", 32'(lif.io_data_o), 32'hCC);
        step();
        check_eq("t1_b3_valid", 32'(lif.io_valid_o), 32'd1);
        check_eq("t1_b3", 32'(lif.io_data_o), 32'hDD);
        step();
        check_eq("t1_end_valid", 32'(lif.io_valid_o), 32'd0);
        repeat (3) step();
        check_eq("t1_hold_data", 32'(lif.io_data_o), 32'hDD);
        check_eq("t1_beats", beat_cnt, 32'd4);
        check_eq("t1_word", rx_q.size() > 0 ? rx_q[0] : 32'hxxxxxxxx, 32'hDDCCBBAA);

        // 10 words, no tokens: 8 go out back-to-back, 2 stay buffered
        reset_dut();
        step();
        for (int i = 0; i < 10; i++) begin
            push(word_of(i));
            if (i == 2) check_eq("t2_full_ready", 32'(lif.core_ready_o), 32'd0);
        end
        repeat (40) step();
        check_eq("t2_beats", beat_cnt, 32'd32);
        check_eq("t2_runs", run_cnt, 32'd1);
        check_eq("t2_words", 32'(rx_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check_eq("t2_word", i < rx_q.size() ? rx_q[i] : 32'hxxxxxxxx, word_of(i));
        check_eq("t2_valid", 32'(lif.io_valid_o), 32'd0);
        check_eq("t2_ready", 32'(lif.core_ready_o), 32'd0);
        check_eq("t2_credit", 32'(dut.credit_q), 32'd0);

        // one token releases exactly two more words
        lif.token_i = 1'b1;
        step();
        lif.token_i = 1'b0;
        check_eq("t3_credit_tok", 32'(dut.credit_q), 32'd2);
        repeat (20) step();
        check_eq("t3_beats", beat_cnt, 32'd40);
        check_eq("t3_runs", run_cnt, 32'd2);
        check_eq("t3_words", 32'(rx_q.size()), 32'd10);
        check_eq("t3_word8", rx_q.size() > 8 ? rx_q[8] : 32'hxxxxxxxx, word_of(8));
        check_eq("t3_word9", rx_q.size() > 9 ? rx_q[9] : 32'hxxxxxxxx, word_of(9));
        check_eq("t3_credit", 32'(dut.credit_q), 32'd0);
        check_eq("t3_ready", 32'(lif.core_ready_o), 32'd1);

        // token on the same edge as a launch with credit 3 -> 4
        reset_dut();
        step();
        for (int i = 0; i < 5; i++) push(word_of(20 + i));
        repeat (30) step();
        check_eq("t4_credit_pre", 32'(dut.credit_q), 32'd3);
        push(32'h87654321);
        lif.token_i = 1'b1;
        step();
        lif.token_i = 1'b0;
        check_eq("t4_credit", 32'(dut.credit_q), 32'd4);
        check_eq("t4_valid", 32'(lif.io_valid_o), 32'd1);
        check_eq("t4_b0", 32'(lif.io_data_o), 32'h21);
        repeat (10) step();
        check_eq("t4_words", 32'(rx_q.size()), 32'd6);
        check_eq("t4_word", rx_q.size() > 5 ? rx_q[5] : 32'hxxxxxxxx, 32'h87654321);

        // asynchronous reset during beat 2
        reset_dut();
        step();
        push(32'h44332211);
        push(32'h88776655);
        step();
        step();
        check_eq("t5_b2_valid", 32'(lif.io_valid_o), 32'd1);
        check_eq("t5_b2", 32'(lif.io_data_o), 32'h33);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_valid", 32'(lif.io_valid_o), 32'd0);
        check_eq("t5_async_data", 32'(lif.io_data_o), 32'd0);
        check_eq("t5_async_ready", 32'(lif.core_ready_o), 32'd0);
        check_eq("t5_async_credit", 32'(dut.credit_q), 32'd8);
        repeat (2) step();
        rst_n = 1'b1;
        beat_cnt = 0;
        repeat (10) step();
        check_eq("t5_no_beats", beat_cnt, 32'd0);
        check_eq("t5_no_words", 32'(rx_q.size()), 32'd0);
        check_eq("t5_fifo_empty", 32'(dut.u_fifo.count_q), 32'd0);
        check_eq("t5_credit", 32'(dut.credit_q), 32'd8);
        check_eq("t5_ready", 32'(lif.core_ready_o), 32'd1);

        // random traffic with credit returned only for received words
        reset_dut();
        step();
        begin
            int unsigned tok_sent = 0;
            int unsigned n = 0;
            for (int c = 0; c < 300; c++) begin
                lif.core_v_i = 1'($urandom_range(0, 1));
                lif.core_data_i = $urandom();
                if (lif.core_v_i && lif.core_ready_o) exp_q.push_back(lif.core_data_i);
                lif.token_i = (rx_q.size() >= 2 * (tok_sent + 1)) && ($urandom_range(0, 3) != 0);
                if (lif.token_i) tok_sent++;
                step();
            end
            lif.core_v_i = 1'b0;
            while (rx_q.size() < exp_q.size() && n < 2000) begin
                lif.token_i = (rx_q.size() >= 2 * (tok_sent + 1));
                if (lif.token_i) tok_sent++;
                step();
                n++;
            end
            lif.token_i = 1'b0;
            if (n >= 2000) check_eq("rnd_drain_timeout", 32'(n), 32'd0);
            check_eq("rnd_count", 32'(rx_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++)
                check_eq("rnd_word", i < rx_q.size() ? rx_q[i] : 32'hxxxxxxxx, exp_q[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
